muldiv_hilo_ctrl: RTL
=====================

Name: muldiv_hilo_ctrl

Overview:
- Sequences the multi-cycle multiply/divide resource of the EX stage and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ALU control stream and stalls the pipeline while an operation runs.
- Commits results to HI/LO atomically; flush cancels an in-flight operation without side effects.

Parameters:
- MUL_CYCLES, 2, cycles spent in the MUL state (>=1); the product is treated as a multi-cycle path.
- DIV_ITERS, 32, radix-2 iterations per divide; fixed to operand width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  valid EX-stage instruction present; held stable by the pipeline while stall_o=1.
- alucontrol  in  5  ALU control code from the shared encodings.
- src_a  in  32  rs operand.
- src_b  in  32  rt operand.
- flush  in  1  exception/cancel; has priority over everything except rst.
- stall_o  out  1  hold IF..EX.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse in the cycle after a mul/div commit.
- hi_o  out  32  current HI register.
- lo_o  out  32  current LO register.

Behaviour:
- Reset: state=IDLE; HI=LO=0; stall_o=busy=done=0; counters and operand latches cleared. rst mid-operation aborts the operation immediately.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start with MULT/MULTU:
  - stall_o=1 combinationally.
  - Latch operands and signedness at the edge; go to MUL with cnt=MUL_CYCLES-1.
- IDLE, start with DIV/DIVU and src_b!=0:
  - stall_o=1 combinationally.
  - Latch |a|, |b| (signed op) or raw values, plus quotient sign (sa^sb) and remainder sign (sa).
  - Go to DIV with iter=DIV_ITERS-1.
- IDLE, DIV/DIVU with src_b==0: no stall, HI/LO unchanged, remain IDLE.
- IDLE, MTHI/MTLO: no stall; HI (or LO) <= src_a at the edge.
- MFHI/MFLO: no action; the ALU reads hi_o/lo_o.
- MUL: stall_o=1. Product is 64-bit signed (MULT) or unsigned (MULTU). When cnt==0: at that edge HI<=prod[63:32], LO<=prod[31:0], go to DONE. Otherwise cnt--.
- DIV:
  - stall_o=1; one restoring step per cycle in the sub-module.
  - When iter==0, at that edge: LO<=quotient and HI<=remainder, with signs applied for DIV; go to DONE.
  - Total stall cycles: DIV = 1 + DIV_ITERS = 33; MULT = 1 + MUL_CYCLES.
- DONE:
  - stall_o=0 and done=1; the pipeline advances on this edge.
  - start/alucontrol are ignored here (same instruction still present); go to IDLE.
- flush=1 in any state: stall_o=0 combinationally, go to IDLE at the edge, no HI/LO write, done=0. flush in IDLE also suppresses MTHI/MTLO writes.
- busy=1 in MUL, DIV and DONE.
- Non-muldiv codes in IDLE: no effect.

Decomposition:
- The shared defines header keeps the ALU control codes (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO _CONTROL). Add state encodings and the DIV_ITERS constant there.
- One sub-module, div_radix2_iter:
  - Behaviour: load on go, one iteration per cycle, outputs quotient/remainder.
  - Unsigned core; sign fixup is handled in muldiv_hilo_ctrl.

Test Plan:
- MULT a=0xFFFFFFFF, b=2 -> stall_o high 3 cycles (MUL_CYCLES=2), then HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulses 1 cycle. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> exactly 33 stall cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=0x0000000E, HI=0x00000002.
- MTHI 0x12345678 followed immediately by MFHI -> no stall, hi_o=0x12345678 one cycle later. DIV by zero -> no stall, HI/LO unchanged.
- DIVU 100/7 with flush asserted in the 10th DIV cycle -> stall_o drops the same cycle, IDLE next cycle, HI/LO keep their prior values, no done.
- rst asserted mid-MUL (asynchronous, between edges) -> HI=LO=0, stall_o=busy=0 immediately. A new MULT 3*5 after release -> LO=15, HI=0.
- Back-to-back DIVU then MULTU, start held through the stalls -> each commits once, with a DONE cycle between them and no double execution.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared ALU control codes, FSM encoding and helpers for the HI/LO multiply/divide unit.
package muldiv_hilo_ctrl_pkg;
    localparam logic [4:0] MULT_CONTROL  = 5'b10000;
    localparam logic [4:0] MULTU_CONTROL = 5'b10001;
    localparam logic [4:0] DIV_CONTROL   = 5'b10010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b10011;
    localparam logic [4:0] MTHI_CONTROL  = 5'b10100;
    localparam logic [4:0] MTLO_CONTROL  = 5'b10101;
    localparam logic [4:0] MFHI_CONTROL  = 5'b10110;
    localparam logic [4:0] MFLO_CONTROL  = 5'b10111;

    localparam int DIV_ITERS = 32;
    localparam int ITER_W    = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_hilo_ctrl_div_radix2_iter.sv
// Unsigned restoring divider, one quotient bit per step.
// quotient/remainder show the result of the step about to be taken, so the last step commits directly.
module div_radix2_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [31:0] q_r, r_r, d_r;
    logic [32:0] r_sh, diff;

    // r_r < d_r always holds, so bit 32 of diff is a clean borrow flag
    always_comb begin
        r_sh = {r_r, q_r[31]};
        diff = r_sh - {1'b0, d_r};
        if (!diff[32]) begin
            quotient  = {q_r[30:0], 1'b1};
            remainder = diff[31:0];
        end else begin
            quotient  = {q_r[30:0], 1'b0};
            remainder = r_sh[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
        end else if (go) begin
            q_r <= dividend;
            r_r <= '0;
            d_r <= divisor;
        end else if (step) begin
            q_r <= quotient;
            r_r <= remainder;
        end
    end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage multiply/divide sequencer owning the HI/LO registers; stalls the pipe while busy.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  alucontrol,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_o,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [ITER_W-1:0] iter;
    logic [31:0]     op_a, op_b, hi_r, lo_r, hi_d, lo_d, dq, dr;
    logic            op_sgn, q_neg, r_neg;
    logic            is_mul, is_div, sgn_in, ld_mul, ld_div, hi_we, lo_we;
    logic [63:0]     prod;

    assign is_mul = (alucontrol == MULT_CONTROL) || (alucontrol == MULTU_CONTROL);
    assign is_div = (alucontrol == DIV_CONTROL)  || (alucontrol == DIVU_CONTROL);
    assign sgn_in = (alucontrol == MULT_CONTROL) || (alucontrol == DIV_CONTROL);

    // Sign-extending to 64 bits lets one truncated multiplier serve MULT and MULTU; multi-cycle path.
    assign prod = {{32{op_sgn & op_a[31]}}, op_a} * {{32{op_sgn & op_b[31]}}, op_b};

    div_radix2_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .go        (ld_div),
        .step      (state == S_DIV),
        .dividend  (abs32(src_a, sgn_in)),
        .divisor   (abs32(src_b, sgn_in)),
        .quotient  (dq),
        .remainder (dr)
    );

    always_comb begin
        state_n = state;
        stall_o = 1'b0;
        ld_mul  = 1'b0;
        ld_div  = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        hi_d    = src_a;
        lo_d    = src_a;
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    if (is_mul) begin
                        stall_o = 1'b1;
                        ld_mul  = 1'b1;
                        state_n = S_MUL;
                    end else if (is_div && src_b != '0) begin
                        stall_o = 1'b1;
                        ld_div  = 1'b1;
                        state_n = S_DIV;
                    end else if (alucontrol == MTHI_CONTROL) begin
                        hi_we = 1'b1;
                    end else if (alucontrol == MTLO_CONTROL) begin
                        lo_we = 1'b1;
                    end
                end
                S_MUL: begin
                    stall_o = 1'b1;
                    if (cnt == '0) begin
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        hi_d    = prod[63:32];
                        lo_d    = prod[31:0];
                        state_n = S_DONE;
                    end
                end
                S_DIV: begin
                    stall_o = 1'b1;
                    if (iter == '0) begin
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        hi_d    = neg_if(dr, r_neg);
                        lo_d    = neg_if(dq, q_neg);
                        state_n = S_DONE;
                    end
                end
                // Same instruction is still on start here; it must not re-issue.
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            iter   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sgn <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            if (ld_mul) begin
                op_a   <= src_a;
                op_b   <= src_b;
                op_sgn <= sgn_in;
                cnt    <= CW'(MUL_CYCLES - 1);
            end else if (state == S_MUL) begin
                cnt <= cnt - CW'(1);
            end
            if (ld_div) begin
                q_neg <= sgn_in & (src_a[31] ^ src_b[31]);
                r_neg <= sgn_in & src_a[31];
                iter  <= ITER_W'(DIV_ITERS - 1);
            end else if (state == S_DIV) begin
                iter <= iter - ITER_W'(1);
            end
            if (hi_we) hi_r <= hi_d;
            if (lo_we) lo_r <= lo_d;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE) && !flush;
    assign hi_o = hi_r;
    assign lo_o = lo_r;
endmodule
